// File: rtl/adpcm_dql_gen.sv
// adpcm_dql_gen: RECONST table lookup plus ADDA scaling in a two-stage valid/ready pipeline.
// Optional output transfer counter o_sample_cnt when ADPCM_DQL_SAMPLE_CNT_EN is defined.
module adpcm_dql_gen #(
  parameter int Y_W = 13,
  parameter int DQL_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [1:0]       i_rate,
  input  logic [4:0]       i_code,
  input  logic [Y_W-1:0]   i_y,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [DQL_W-1:0] o_dql,
  output logic             o_dqs
`ifdef ADPCM_DQL_SAMPLE_CNT_EN
  , output logic [15:0]    o_sample_cnt
`endif
);
  localparam int T16 [4]  = '{116, 365, 365, 116};
  localparam int T24 [8]  = '{-2048, 135, 273, 373, 373, 273, 135, -2048};
  localparam int T32 [16] = '{-2048, 4, 135, 213, 273, 323, 373, 425,
                              425, 373, 323, 273, 213, 135, 4, -2048};
  localparam int T40 [32] = '{-2048, -66, 28, 104, 169, 224, 274, 318,
                              358, 401, 440, 474, 506, 542, 568, 594,
                              594, 568, 542, 506, 474, 440, 401, 358,
                              318, 274, 224, 169, 104, 28, -66, -2048};

  logic             s1_valid, s1_dqs, s1_en, s2_en, dqs;
  logic [DQL_W-1:0] s1_dqln, dqln;
  logic [Y_W-3:0]   s1_y4;

  assign s2_en   = !o_valid || o_ready;
  assign s1_en   = !s1_valid || s2_en;
  assign i_ready = s1_en;

  // Only the low N bits of the codeword select the entry; the top one of them is the sign.
  always_comb begin
    dqs  = i_rate == 2'd0 ? i_code[1] : i_rate == 2'd1 ? i_code[2] :
           i_rate == 2'd2 ? i_code[3] : i_code[4];
    dqln = i_rate == 2'd0 ? DQL_W'(T16[i_code[1:0]]) :
           i_rate == 2'd1 ? DQL_W'(T24[i_code[2:0]]) :
           i_rate == 2'd2 ? DQL_W'(T32[i_code[3:0]]) : DQL_W'(T40[i_code[4:0]]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_dqln  <= '0;
      s1_dqs   <= 1'b0;
      s1_y4    <= '0;
    end else if (s1_en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_dqln <= dqln;
        s1_dqs  <= dqs;
        s1_y4   <= i_y[Y_W-1:2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_dql   <= '0;
      o_dqs   <= 1'b0;
    end else if (s2_en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_dql <= s1_dqln + DQL_W'(s1_y4);
        o_dqs <= s1_dqs;
      end
    end
  end

`ifdef ADPCM_DQL_SAMPLE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) o_sample_cnt <= '0;
    else if (o_valid && o_ready) o_sample_cnt <= o_sample_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_adpcm_dql_gen.sv
// tb_adpcm_dql_gen: directed table vectors plus latency, streaming, backpressure and reset sequences.
module tb_adpcm_dql_gen;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        i_valid = 1'b0, i_ready, o_valid, o_ready = 1'b1, o_dqs;
  logic [1:0]  i_rate = '0;
  logic [4:0]  i_code = '0;
  logic [12:0] i_y = '0;
  logic [11:0] o_dql;
`ifdef ADPCM_DQL_SAMPLE_CNT_EN
  logic [15:0] o_sample_cnt;
`endif
  int errors = 0, checks = 0;

  adpcm_dql_gen dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_rate(i_rate), .i_code(i_code), .i_y(i_y), .o_valid(o_valid),
    .o_ready(o_ready), .o_dql(o_dql), .o_dqs(o_dqs)
`ifdef ADPCM_DQL_SAMPLE_CNT_EN
    , .o_sample_cnt(o_sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  rate;
    logic [4:0]  code;
    logic [12:0] y;
    logic [11:0] dql;
    logic        dqs;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [4:0] c, input logic [12:0] y);
    i_valid = 1'b1; i_rate = r; i_code = c; i_y = y;
  endtask

  vec_t v [10];

  initial begin
    v[0] = '{"r2_i3",     2'd2, 5'b00011, 13'd1024, 12'd469,  1'b0};
    v[1] = '{"r2_i12",    2'd2, 5'b01100, 13'd1024, 12'd469,  1'b1};
    v[2] = '{"r2_zero",   2'd2, 5'b00000, 13'd0,    12'h800,  1'b0};
    v[3] = '{"r3_wrap",   2'd3, 5'b00001, 13'd1000, 12'd184,  1'b0};
    v[4] = '{"r0_i1",     2'd0, 5'b00001, 13'd0,    12'd365,  1'b0};
    v[5] = '{"r1_i3",     2'd1, 5'b00011, 13'd0,    12'd373,  1'b0};
    v[6] = '{"r3_i16",    2'd3, 5'b10000, 13'd0,    12'd594,  1'b1};
    v[7] = '{"r1_ymax",   2'd1, 5'b00111, 13'd8191, 12'd4095, 1'b1};
    v[8] = '{"r0_upper",  2'd0, 5'b11110, 13'd4,    12'd366,  1'b1};
    v[9] = '{"r3_i9",     2'd3, 5'b01001, 13'd400,  12'd501,  1'b0};

    #12;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_dql", o_dql, 0);
    chk("rst_o_dqs", o_dqs, 0);
    chk("rst_i_ready", i_ready, 1);
    @(negedge clk); reset_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk); drive(v[k].rate, v[k].code, v[k].y);
      @(negedge clk); i_valid = 1'b0;
      chk({v[k].name, "_lat"}, o_valid, 0);
      @(negedge clk);
      chk({v[k].name, "_valid"}, o_valid, 1);
      chk({v[k].name, "_dql"}, o_dql, v[k].dql);
      chk({v[k].name, "_dqs"}, o_dqs, v[k].dqs);
    end

    @(negedge clk); drive(2'd0, 5'd1, 13'd0);
    @(negedge clk); drive(2'd1, 5'd3, 13'd0);
    @(negedge clk); drive(2'd3, 5'b10000, 13'd0);
    chk("b2b_0_valid", o_valid, 1); chk("b2b_0_dql", o_dql, 365); chk("b2b_0_dqs", o_dqs, 0);
    @(negedge clk); i_valid = 1'b0;
    chk("b2b_1_valid", o_valid, 1); chk("b2b_1_dql", o_dql, 373); chk("b2b_1_dqs", o_dqs, 0);
    @(negedge clk);
    chk("b2b_2_valid", o_valid, 1); chk("b2b_2_dql", o_dql, 594); chk("b2b_2_dqs", o_dqs, 1);
    @(negedge clk);
    chk("b2b_empty", o_valid, 0);
    chk("b2b_hold", o_dql, 594);

    @(negedge clk); o_ready = 1'b0; drive(2'd2, 5'd1, 13'd0);
    @(negedge clk);
    chk("bp_ready1", i_ready, 1);
    drive(2'd2, 5'd2, 13'd0);
    @(negedge clk);
    chk("bp_full", i_ready, 0);
    drive(2'd2, 5'd4, 13'd4);
    for (int k = 0; k < 4; k++) begin
      chk("bp_stall_valid", o_valid, 1);
      chk("bp_stall_dql", o_dql, 4);
      chk("bp_stall_ready", i_ready, 0);
      if (k < 3) @(negedge clk);
    end
    o_ready = 1'b1;
    @(negedge clk); i_valid = 1'b0;
    chk("bp_out1_valid", o_valid, 1); chk("bp_out1_dql", o_dql, 135);
    @(negedge clk);
    chk("bp_out2_valid", o_valid, 1); chk("bp_out2_dql", o_dql, 274);
    @(negedge clk);
    chk("bp_drained", o_valid, 0);

    o_ready = 1'b0; drive(2'd3, 5'b10000, 13'd0);
    @(negedge clk);
    @(negedge clk); i_valid = 1'b0;
    chk("pre_rst_full", i_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_o_valid", o_valid, 0);
    chk("arst_o_dql", o_dql, 0);
    chk("arst_o_dqs", o_dqs, 0);
    chk("arst_i_ready", i_ready, 1);
    @(negedge clk); reset_n = 1'b1; o_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", i_ready, 1);
    chk("post_rst_valid", o_valid, 0);

`ifdef ADPCM_DQL_SAMPLE_CNT_EN
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("cnt_rst", o_sample_cnt, 0);
    drive(2'd2, 5'd3, 13'd0);
    for (int k = 0; k < 65537; k++) @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("cnt_wrap", o_sample_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
